regfile_sb: RTL and testbench

Parametrised multi-read-port register file with an integrated write-reservation scoreboard and a sequential bulk-clear engine. Sits in the decode/writeback boundary of the pipelined core. Decode reads operands and reserves destination registers. Writeback commits results and releases the reservations. Register 0 reads as zero and is never writable.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 57 +++++
 rtl/regfile_sb.sv | 127 ++++++++++++
 tb/tb_regfile_sb.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and default widths for the regfile_sb register file.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_e;

    typedef logic [RF_ADDR_W-1:0] rf_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-reservation scoreboard: one busy bit per register, reserve-wins
// priority over a same-cycle writeback, and the rsv_ready handshake.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = RF_ADDR_W,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              idle,
    input  logic              clr_all,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    output logic [DEPTH-1:0]  busy
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_acc;
    logic             rsv_acc;

    // A pending write to the same register frees it in time for a re-reserve.
    assign rsv_ready = idle && !(busy_q[rsv_addr] && !(wen && (waddr == rsv_addr)));
    assign rsv_acc   = rsv_valid && rsv_ready;
    assign wr_acc    = wen && idle;

    // NOTE: defaulting every combinational output first keeps this a pure mux, never a latch.
    always_comb begin
        busy_d = busy_q;
        if (clr_all) begin
            busy_d = '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_acc && (waddr == ADDR_W'(i)))
                    busy_d[i] = 1'b0;
                if (rsv_acc && (rsv_addr == ADDR_W'(i)))
                    busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignment so all flops sample the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with reservation scoreboard and bulk clear.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int ADDR_W = RF_ADDR_W,
    parameter  int NUM_RD = 2,
    localparam int DEPTH  = 1 << ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     wen,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     rsv_valid,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ready,
    input  logic                     clr_req,
    output logic                     clr_busy,
    input  logic [ADDR_W-1:0]        dbg_addr,
    output logic [DATA_W-1:0]        dbg_data
);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              idle;
    logic              clr_all;
    logic              wr_acc;
    logic [DEPTH-1:0]  busy;

    logic [DATA_W-1:0] regs [1:DEPTH-1];
    logic [DATA_W-1:0] view [DEPTH];

    assign idle     = (state_q == RF_IDLE);
    assign clr_busy = (state_q == RF_CLEAR);
    assign clr_all  = idle && clr_req;
    assign wr_acc   = wen && idle && (waddr != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = ADDR_W'(1);
                end
            end
            RF_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == {ADDR_W{1'b1}}) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the array is flops, not a RAM macro, so it takes the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (clr_busy && (idx_q == ADDR_W'(i)))
                    regs[i] <= '0;
                else if (wr_acc && (waddr == ADDR_W'(i)))
                    regs[i] <= wdata;
            end
        end
    end

    // Entry 0 is hardwired so every read path sees a full DEPTH-entry view.
    always_comb begin
        view[0] = '0;
        for (int i = 1; i < DEPTH; i++)
            view[i] = regs[i];
    end

    assign dbg_data = view[dbg_addr];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = raddr[p*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        logic hit;
        assign hit                     = wr_acc && (waddr == ra);
        assign rdata[p*DATA_W +: DATA_W] = hit ? wdata : view[ra];
        assign rbusy[p]                = busy[ra] && !hit;
`else
        assign rdata[p*DATA_W +: DATA_W] = view[ra];
        assign rbusy[p]                = busy[ra];
`endif
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (idle),
        .clr_all   (clr_all),
        .wen       (wen),
        .waddr     (waddr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .busy      (busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus random traffic
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 1 << AW;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              wen;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              rsv_ready;
    logic              clr_req;
    logic              clr_busy;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;
    rf_idx_t           ra [NR];

    assign raddr = {ra[1], ra[0]};

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays plus a countdown of remaining clear cycles.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    int            m_clr_left;
    int            m_clr_idx;

    int  n_checks;
    int  n_fail;
    bit  last_clr_busy;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
        m_clr_left = 0;
        m_clr_idx  = 0;
    endfunction

    task automatic idle_inputs();
        wen       = 1'b0;
        waddr     = '0;
        wdata     = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        clr_req   = 1'b0;
        dbg_addr  = '0;
        for (int p = 0; p < NR; p++) ra[p] = '0;
    endtask

    // Check all combinational outputs against the model, clock once, advance the model.
    task automatic step();
        bit            idle;
        bit            exp_ready;
        bit            byp;
        logic [DW-1:0] exp_d;
        bit            exp_b;
        #1;
        idle      = (m_clr_left == 0);
        exp_ready = idle && !(m_busy[rsv_addr] && !(wen && waddr == rsv_addr));
        for (int p = 0; p < NR; p++) begin
            byp   = BYP && idle && wen && (waddr != 0) && (waddr == ra[p]);
            exp_d = byp ? wdata : m_mem[ra[p]];
            exp_b = byp ? 1'b0 : m_busy[ra[p]];
            check($sformatf("rdata%0d[r%0d]", p, ra[p]), rdata[p*DW +: DW], exp_d);
            check($sformatf("rbusy%0d[r%0d]", p, ra[p]), rbusy[p], exp_b);
        end
        check("rsv_ready", rsv_ready, exp_ready);
        check("clr_busy", clr_busy, !idle);
        check($sformatf("dbg_data[r%0d]", dbg_addr), dbg_data, m_mem[dbg_addr]);
        last_clr_busy = clr_busy;
        @(posedge clk);
        if (!idle) begin
            m_mem[m_clr_idx] = '0;
            m_clr_idx++;
            m_clr_left--;
        end else begin
            if (wen && waddr != 0) begin
                m_mem[waddr]  = wdata;
                m_busy[waddr] = 1'b0;
            end
            if (rsv_valid && exp_ready && rsv_addr != 0)
                m_busy[rsv_addr] = 1'b1;
            if (clr_req) begin
                for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
                m_clr_idx  = 1;
                m_clr_left = DEPTH - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic fill_by_index();
        for (int i = 1; i < DEPTH; i++) begin
            idle_inputs();
            wen   = 1'b1;
            waddr = AW'(i);
            wdata = DW'(i);
            step();
        end
        idle_inputs();
    endtask

    initial begin
        int clr_cycles;
        n_checks = 0;
        n_fail   = 0;
        idle_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state across every address.
        for (int a = 0; a < DEPTH; a++) begin
            ra[0]    = AW'(a);
            ra[1]    = AW'(DEPTH - 1 - a);
            dbg_addr = AW'(a);
            #1;
            check("rst_rdata0", rdata[DW-1:0], 0);
            check("rst_rbusy", rbusy, 0);
            check("rst_rsv_ready", rsv_ready, 1);
            step();
        end

        // Basic write/read, write to r0 dropped.
        idle_inputs();
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        idle_inputs();
        ra[1] = 5'd5;
        #1 check("r5_port1", rdata[2*DW-1:DW], 32'hDEADBEEF);
        step();
        idle_inputs();
        wen = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        step();
        idle_inputs();
        #1 check("r0_zero", rdata[DW-1:0], 0);
        step();

        // Reservation, blocked re-reserve, then write + re-reserve together.
        idle_inputs();
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        ra[0] = 5'd7;
        #1;
        check("r7_rsv_blocked", rsv_ready, 0);
        check("r7_busy", rbusy[0], 1);
        step();
        idle_inputs();
        wen = 1'b1; waddr = 5'd7; wdata = 32'h55;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        #1 check("r7_rsv_with_write", rsv_ready, 1);
        step();
        idle_inputs();
        ra[0] = 5'd7;
        #1;
        check("r7_busy_kept", rbusy[0], 1);
        check("r7_data", rdata[DW-1:0], 32'h55);
        step();

        // Same-cycle write/read of r3 with r3 reserved.
        idle_inputs();
        wen = 1'b1; waddr = 5'd3; wdata = 32'h11;
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        step();
        idle_inputs();
        wen = 1'b1; waddr = 5'd3; wdata = 32'hA5A5A5A5;
        ra[0] = 5'd3;
        #1;
        check("r3_bypass_data", rdata[DW-1:0], BYP ? 32'hA5A5A5A5 : 32'h11);
        check("r3_bypass_busy", rbusy[0], BYP ? 1'b0 : 1'b1);
        step();

        // Bulk clear with a write attempted mid-clear.
        fill_by_index();
        idle_inputs();
        rsv_valid = 1'b1; rsv_addr = 5'd12;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_cycles = 0;
        for (int n = 0; n < 100; n++) begin
            idle_inputs();
            if (clr_cycles == 5) begin
                wen = 1'b1; waddr = 5'd9; wdata = 32'hFFFF;
            end
            ra[0] = AW'($urandom_range(0, DEPTH - 1));
            step();
            if (last_clr_busy) clr_cycles++;
            else break;
        end
        check("clr_cycles", clr_cycles, DEPTH - 1);
        for (int a = 0; a < DEPTH; a++) begin
            idle_inputs();
            ra[0]    = AW'(a);
            dbg_addr = AW'(a);
            #1;
            check($sformatf("post_clr_dbg[r%0d]", a), dbg_data, 0);
            check($sformatf("post_clr_busy[r%0d]", a), rbusy[0], 0);
            step();
        end

        // Reset asserted ten cycles into a clear.
        fill_by_index();
        clr_req = 1'b1;
        step();
        idle_inputs();
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        check("mid_clr_rst_busy", clr_busy, 0);
        check("mid_clr_rst_ready", rsv_ready, 1);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_addr = AW'(a);
            #1 check($sformatf("mid_clr_rst_dbg[r%0d]", a), dbg_data, 0);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            wen       = 1'($urandom_range(0, 1));
            waddr     = AW'($urandom_range(0, DEPTH - 1));
            wdata     = DW'($urandom);
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            clr_req   = ($urandom_range(0, 63) == 0);
            dbg_addr  = AW'($urandom_range(0, DEPTH - 1));
            ra[0]     = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, DEPTH - 1));
            ra[1]     = AW'($urandom_range(0, DEPTH - 1));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
